// File: rtl/fifo_pixel_unpacker.sv
// rtl/fifo_pixel_unpacker.sv - unpacks 32-bit FIFO words into an RGB565 pixel stream with EOL and underflow tracking
module fifo_pixel_unpacker #(
    parameter int HALF_ORDER = 0,
    parameter int H_ACTIVE   = 640,
    parameter int CNT_W      = 16
) (
    input  logic             rd_clk,
    input  logic             rd_rst,
    output logic             fifo_rd_en,
    input  logic [31:0]      fifo_rd_data,
    input  logic             fifo_rd_empty,
    input  logic             stream_en,
    input  logic             flush,
    output logic             pix_valid,
    input  logic             pix_ready,
    output logic [15:0]      pix_data,
    output logic             pix_eol,
    output logic             underflow,
    output logic [CNT_W-1:0] underflow_cnt
);

    localparam logic [11:0] LAST = 12'(H_ACTIVE - 1);

    logic [31:0] head;
    logic [31:0] tail;
    logic [1:0]  occ;
    logic        half_sel;
    logic        inflight;
    logic        drop;
    logic [11:0] pix_cnt;

    logic        xfer;
    logic        pop;
    logic        wr;
    logic        uf_hit;
    logic [2:0]  next_fill;

    always_comb begin
        pix_valid = (occ != 2'd0) & ~flush;
        xfer      = pix_valid & pix_ready;
        pop       = xfer & half_sel;
        wr        = inflight & ~drop & ~flush;
        // occ + inflight never exceeds 2, so pop can only lower a non-negative fill
        next_fill  = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
        fifo_rd_en = ~rd_rst & ~fifo_rd_empty & ~flush & (next_fill < 3'd2);
        pix_data   = (half_sel ^ (HALF_ORDER != 0)) ? head[31:16] : head[15:0];
        pix_eol    = pix_valid & (pix_cnt == LAST);
        uf_hit     = stream_en & pix_ready & ~pix_valid & ~flush;
    end

    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            head          <= 32'd0;
            tail          <= 32'd0;
            occ           <= 2'd0;
            half_sel      <= 1'b0;
            inflight      <= 1'b0;
            drop          <= 1'b0;
            pix_cnt       <= 12'd0;
            underflow     <= 1'b0;
            underflow_cnt <= '0;
        end else begin
            inflight <= fifo_rd_en & ~fifo_rd_empty;
            drop     <= flush & inflight;
            if (uf_hit) begin
                underflow <= 1'b1;
                if (~&underflow_cnt)
                    underflow_cnt <= underflow_cnt + CNT_W'(1);
            end
            if (flush) begin
                occ      <= 2'd0;
                half_sel <= 1'b0;
                pix_cnt  <= 12'd0;
            end else begin
                if (xfer) begin
                    half_sel <= ~half_sel;
                    pix_cnt  <= (pix_cnt == LAST) ? 12'd0 : pix_cnt + 12'd1;
                end
                // head is the word being emitted; tail holds the next one
                case ({wr, pop})
                    2'b10: begin
                        if (occ == 2'd0) head <= fifo_rd_data;
                        else             tail <= fifo_rd_data;
                        occ <= occ + 2'd1;
                    end
                    2'b01: begin
                        head <= tail;
                        occ  <= occ - 2'd1;
                    end
                    2'b11: begin
                        if (occ == 2'd1) begin
                            head <= fifo_rd_data;
                        end else begin
                            head <= tail;
                            tail <= fifo_rd_data;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fifo_pixel_unpacker.sv
// tb/tb_fifo_pixel_unpacker.sv - self-checking bench for fifo_pixel_unpacker with FIFO and pixel-order models
module tb_fifo_pixel_unpacker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, stream_en, flush, pix_ready, fifo_clr;

    logic        rd_en0, empty0, valid0, eol0, uf0;
    logic [31:0] rd_data0;
    logic [15:0] data0;
    logic [3:0]  ufc0;

    logic        rd_en1, empty1, valid1, eol1, uf1;
    logic [31:0] rd_data1;
    logic [15:0] data1;
    logic [15:0] ufc1;

    fifo_pixel_unpacker #(.HALF_ORDER(0), .H_ACTIVE(5), .CNT_W(4)) dut0 (
        .rd_clk(clk), .rd_rst(rst), .fifo_rd_en(rd_en0), .fifo_rd_data(rd_data0),
        .fifo_rd_empty(empty0), .stream_en(stream_en), .flush(flush),
        .pix_valid(valid0), .pix_ready(pix_ready), .pix_data(data0), .pix_eol(eol0),
        .underflow(uf0), .underflow_cnt(ufc0)
    );

    fifo_pixel_unpacker #(.HALF_ORDER(1), .H_ACTIVE(640), .CNT_W(16)) dut1 (
        .rd_clk(clk), .rd_rst(rst), .fifo_rd_en(rd_en1), .fifo_rd_data(rd_data1),
        .fifo_rd_empty(empty1), .stream_en(stream_en), .flush(flush),
        .pix_valid(valid1), .pix_ready(pix_ready), .pix_data(data1), .pix_eol(eol1),
        .underflow(uf1), .underflow_cnt(ufc1)
    );

    // source FIFO models: 1-cycle read latency, no output register
    logic [31:0] mem0 [0:2047];
    logic [31:0] mem1 [0:15];
    int wp0 = 0, rp0 = 0, reads0 = 0;
    int wp1 = 0, rp1 = 0;
    assign empty0 = (wp0 == rp0);
    assign empty1 = (wp1 == rp1);

    always @(posedge clk) begin
        if (fifo_clr) begin
            rp0 <= wp0;
        end else if (rd_en0 && (rp0 != wp0)) begin
            rd_data0 <= mem0[rp0];
            rp0      <= rp0 + 1;
            reads0   <= reads0 + 1;
        end
    end

    always @(posedge clk) begin
        if (rd_en1 && (rp1 != wp1)) begin
            rd_data1 <= mem1[rp1];
            rp1      <= rp1 + 1;
        end
    end

    logic [15:0] exp0[$];
    logic [15:0] exp1[$];
    int total = 0, bad = 0;
    int xfers0 = 0, xfers1 = 0, pops0 = 0, occ_adj = 0, eol_seen0 = 0;
    logic hs0 = 1'b0;
    logic pv = 1'b0, pr = 1'b0, pf = 1'b0, pe = 1'b0;
    logic [15:0] pd = 16'd0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic push0(input logic [31:0] w);
        mem0[wp0] = w;
        wp0++;
        exp0.push_back(w[15:0]);
        exp0.push_back(w[31:16]);
    endtask

    task automatic push1(input logic [31:0] w);
        mem1[wp1] = w;
        wp1++;
        exp1.push_back(w[31:16]);
        exp1.push_back(w[15:0]);
    endtask

    task automatic cycle();
        logic [15:0] e;
        #1;
        chk("rd_en_while_empty", {31'd0, rd_en0 & empty0}, 32'd0);
        chk("occ_le_2", {31'd0, (reads0 - pops0 - occ_adj) <= 2}, 32'd1);
        if (pv && !pr && !pf && !flush) begin
            chk("hold_valid", {31'd0, valid0}, 32'd1);
            chk("hold_data", {16'd0, data0}, {16'd0, pd});
            chk("hold_eol", {31'd0, eol0}, {31'd0, pe});
        end
        if (valid0 && pix_ready) begin
            if (exp0.size() == 0) begin
                chk("dut0_extra_pixel", exp0.size(), 32'd1);
            end else begin
                e = exp0.pop_front();
                chk("dut0_pix", {16'd0, data0}, {16'd0, e});
                chk("dut0_eol", {31'd0, eol0}, {31'd0, (xfers0 % 5) == 4});
                if (eol0) eol_seen0++;
                xfers0++;
                if (hs0) pops0++;
                hs0 = ~hs0;
            end
        end
        if (valid1 && pix_ready) begin
            if (exp1.size() == 0) begin
                chk("dut1_extra_pixel", exp1.size(), 32'd1);
            end else begin
                e = exp1.pop_front();
                chk("dut1_pix", {16'd0, data1}, {16'd0, e});
                chk("dut1_eol", {31'd0, eol1}, {31'd0, (xfers1 % 640) == 639});
                xfers1++;
            end
        end
        pv = valid0; pr = pix_ready; pf = flush; pd = data0; pe = eol0;
        @(negedge clk);
    endtask

    logic [31:0] wc;
    int guard;

    initial begin
        rst = 1'b1; stream_en = 1'b0; flush = 1'b0; pix_ready = 1'b0; fifo_clr = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_rd_en", {31'd0, rd_en0}, 32'd0);
        chk("rst_valid", {31'd0, valid0}, 32'd0);
        chk("rst_data", {16'd0, data0}, 32'd0);
        chk("rst_eol", {31'd0, eol0}, 32'd0);
        chk("rst_uf", {31'd0, uf0}, 32'd0);
        chk("rst_ufc", {28'd0, ufc0}, 32'd0);
        rst = 1'b0;

        // first-read latency and back-to-back pixels, both half orders
        push0(32'h22221111); push0(32'h44443333);
        push1(32'h22221111); push1(32'h44443333);
        pix_ready = 1'b1;
        #1;
        chk("lat_rd_en_c0", {31'd0, rd_en0}, 32'd1);
        chk("lat_valid_c0", {31'd0, valid0}, 32'd0);
        cycle();
        #1 chk("lat_valid_c1", {31'd0, valid0}, 32'd0);
        cycle();
        #1 chk("lat_valid_c2", {31'd0, valid0}, 32'd1);
        chk("lat_first_pix", {16'd0, data0}, 32'h1111);
        chk("lat_first_pix_ho1", {16'd0, data1}, 32'h2222);
        cycle();
        for (int i = 0; i < 3; i++) begin
            #1 chk("lat_consecutive", {31'd0, valid0}, 32'd1);
            cycle();
        end
        repeat (2) cycle();
        chk("lat_drain0", exp0.size(), 32'd0);
        chk("lat_drain1", exp1.size(), 32'd0);

        // line-end marking across word boundaries
        for (int i = 0; i < 10; i++) push0($urandom);
        repeat (25) cycle();
        chk("eol_drain", exp0.size(), 32'd0);
        chk("eol_count", eol_seen0, 32'd4);

        // underflow counting, stickiness, saturation
        stream_en = 1'b1;
        repeat (7) cycle();
        stream_en = 1'b0;
        #1;
        chk("uf_cnt7", {28'd0, ufc0}, 32'd7);
        chk("uf_flag", {31'd0, uf0}, 32'd1);
        chk("uf_cnt7_dut1", {16'd0, ufc1}, 32'd7);
        push0($urandom);
        repeat (4) cycle();
        chk("uf_held_cnt", {28'd0, ufc0}, 32'd7);
        chk("uf_held_flag", {31'd0, uf0}, 32'd1);
        stream_en = 1'b1;
        repeat (20) cycle();
        stream_en = 1'b0;
        #1;
        chk("uf_saturate", {28'd0, ufc0}, 32'hF);
        chk("uf_cnt27_dut1", {16'd0, ufc1}, 32'd27);

        // flush mid-word with a read in flight
        pix_ready = 1'b0;
        push0(32'hA1A2A3A4);
        repeat (3) cycle();
        pix_ready = 1'b1;
        cycle();
        pix_ready = 1'b0;
        push0(32'hB1B2B3B4);
        wc = $urandom;
        push0(wc);
        #1 chk("fl_rd_en_pre", {31'd0, rd_en0}, 32'd1);
        cycle();
        flush = 1'b1; pix_ready = 1'b1;
        #1;
        chk("fl_valid", {31'd0, valid0}, 32'd0);
        chk("fl_rd_en", {31'd0, rd_en0}, 32'd0);
        cycle();
        flush = 1'b0;
        exp0.delete();
        exp0.push_back(wc[15:0]);
        exp0.push_back(wc[31:16]);
        xfers0 = 0; hs0 = 1'b0; xfers1 = 0;
        occ_adj = reads0 - pops0;
        #1 chk("fl_after_valid_c0", {31'd0, valid0}, 32'd0);
        cycle();
        #1 chk("fl_after_valid_c1", {31'd0, valid0}, 32'd0);
        cycle();
        #1 chk("fl_next_pix", {16'd0, data0}, {16'd0, wc[15:0]});
        cycle();
        repeat (3) cycle();
        chk("fl_drain", exp0.size(), 32'd0);

        // random backpressure against the pixel-order model
        for (int i = 0; i < 1000; i++) push0($urandom);
        guard = 0;
        while (exp0.size() != 0 && guard < 8000) begin
            pix_ready = 1'($urandom_range(0, 1));
            cycle();
            guard++;
        end
        chk("rand_drain", exp0.size(), 32'd0);
        pix_ready = 1'b1;

        // asynchronous reset mid-stream
        for (int i = 0; i < 4; i++) push0($urandom);
        repeat (4) cycle();
        #2 rst = 1'b1;
        #1;
        chk("arst_rd_en", {31'd0, rd_en0}, 32'd0);
        chk("arst_valid", {31'd0, valid0}, 32'd0);
        chk("arst_data", {16'd0, data0}, 32'd0);
        chk("arst_eol", {31'd0, eol0}, 32'd0);
        chk("arst_ufc", {28'd0, ufc0}, 32'd0);
        chk("arst_uf", {31'd0, uf0}, 32'd0);
        @(negedge clk);
        chk("arst_hold_valid", {31'd0, valid0}, 32'd0);
        fifo_clr = 1'b1;
        @(negedge clk);
        fifo_clr = 1'b0;
        rst = 1'b0;
        exp0.delete(); exp1.delete();
        xfers0 = 0; xfers1 = 0; hs0 = 1'b0; pv = 1'b0;
        occ_adj = reads0 - pops0;
        repeat (3) cycle();
        #1;
        chk("post_rst_valid", {31'd0, valid0}, 32'd0);
        chk("post_rst_ufc", {28'd0, ufc0}, 32'd0);
        for (int i = 0; i < 4; i++) push0($urandom);
        repeat (12) cycle();
        chk("post_rst_drain", exp0.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
